// File: rtl/tx_packet_scheduler_if.sv
// ---------------------------------------------------------------------------
// tx_packet_scheduler_if
// Bundles the request side (handshake + data requests), the TX FSM status
// flags and the scheduler outputs into one connection.
//   master : the scheduler itself (consumes requests/status, drives launch,
//            grant, completion and status outputs)
//   slave  : the surrounding environment (request sources + TX FSM)
// Signals:
//   hs_req/hs_type        handshake request, type 01 ACK 10 NAK 11 STALL
//   data_req/data_len     data-packet request and payload size (0..64)
//   buff_occ              TX buffer occupancy in bytes
//   TX_Transfer_Active    TX FSM busy flag
//   TX_Error              TX FSM error flag
//   TX_packet/tx_start    packet type and one-cycle launch strobe
//   hs_gnt/data_gnt       one-cycle grant pulses
//   hs_done/data_done     one-cycle clean-completion pulses
//   tx_err/timeout/busy   error pulse, sticky start timeout, non-idle flag
// ---------------------------------------------------------------------------
interface tx_packet_scheduler_if;
   logic       hs_req;
   logic [1:0] hs_type;
   logic       data_req;
   logic [6:0] data_len;
   logic [6:0] buff_occ;
   logic       TX_Transfer_Active;
   logic       TX_Error;
   logic [1:0] TX_packet;
   logic       tx_start;
   logic       hs_gnt;
   logic       data_gnt;
   logic       hs_done;
   logic       data_done;
   logic       tx_err;
   logic       timeout;
   logic       busy;

   modport master (
      input  hs_req, hs_type, data_req, data_len, buff_occ,
             TX_Transfer_Active, TX_Error,
      output TX_packet, tx_start, hs_gnt, data_gnt, hs_done, data_done,
             tx_err, timeout, busy
   );

   modport slave (
      output hs_req, hs_type, data_req, data_len, buff_occ,
             TX_Transfer_Active, TX_Error,
      input  TX_packet, tx_start, hs_gnt, data_gnt, hs_done, data_done,
             tx_err, timeout, busy
   );
endinterface

// File: rtl/tx_packet_scheduler.sv
// ---------------------------------------------------------------------------
// tx_packet_scheduler
// Arbitrates handshake vs data packet requests, launches one packet at a
// time into the TX FSM and tracks it to completion, with a start timeout,
// a minimum inter-packet gap and data anti-starvation.
// Ports:
//   clk    rising-edge system clock
//   n_rst  synchronous active-low reset
//   bus    tx_packet_scheduler_if.master (requests, TX status, outputs)
// Parameters:
//   START_TIMEOUT  cycles allowed from tx_start until TX_Transfer_Active
//   GAP_CYCLES     idle cycles after every packet end/error (0 = none)
//   MAX_HS_STREAK  handshake grants allowed while eligible data waits
// ---------------------------------------------------------------------------
module tx_packet_scheduler #(
   parameter int START_TIMEOUT = 16,
   parameter int GAP_CYCLES    = 4,
   parameter int MAX_HS_STREAK = 3
) (
   input  logic                   clk,
   input  logic                   n_rst,
   tx_packet_scheduler_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_ACTIVE,
      S_ACTIVE,
      S_DONE,
      S_ERR,
      S_GAP
   } state_t;

   localparam logic [7:0] L_TIMER_LAST = 8'(START_TIMEOUT - 1);
   localparam logic [7:0] L_GAP        = 8'(GAP_CYCLES);
   localparam logic [3:0] L_STREAK_MAX = 4'(MAX_HS_STREAK);

   state_t     r_state;
   logic [7:0] r_timer;
   logic [7:0] r_gap;
   logic [3:0] r_streak;
   logic [1:0] r_pkt;
   logic       r_start;
   logic       r_hs_gnt;
   logic       r_data_gnt;
   logic       r_hs_done;
   logic       r_data_done;
   logic       r_err;
   logic       r_timeout;
   logic       r_busy;

   logic w_hs_valid;
   logic w_data_elig;
   logic w_streak_full;
   logic w_grant_hs;
   logic w_grant_data;

   assign w_hs_valid    = bus.hs_req && (bus.hs_type != 2'b00);
   assign w_data_elig   = bus.data_req && (bus.data_len <= 7'd64) &&
                          (bus.buff_occ >= bus.data_len);
   assign w_streak_full = (r_streak == L_STREAK_MAX);

   // Data only beats a valid handshake once the handshake streak is full.
   assign w_grant_data  = (r_state == S_IDLE) && w_data_elig &&
                          (!w_hs_valid || w_streak_full);
   assign w_grant_hs    = (r_state == S_IDLE) && w_hs_valid && !w_grant_data;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_state     <= S_IDLE;
         r_timer     <= '0;
         r_gap       <= '0;
         r_streak    <= '0;
         r_pkt       <= '0;
         r_start     <= 1'b0;
         r_hs_gnt    <= 1'b0;
         r_data_gnt  <= 1'b0;
         r_hs_done   <= 1'b0;
         r_data_done <= 1'b0;
         r_err       <= 1'b0;
         r_timeout   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_start     <= 1'b0;
         r_hs_gnt    <= 1'b0;
         r_data_gnt  <= 1'b0;
         r_hs_done   <= 1'b0;
         r_data_done <= 1'b0;
         r_err       <= 1'b0;

         if (!bus.data_req || w_grant_data) begin
            r_streak <= '0;
         end else if (w_grant_hs && !w_streak_full) begin
            r_streak <= r_streak + 4'd1;
         end

         case (r_state)
            S_IDLE: begin
               if (w_grant_hs || w_grant_data) begin
                  r_start    <= 1'b1;
                  r_hs_gnt   <= w_grant_hs;
                  r_data_gnt <= w_grant_data;
                  r_pkt      <= w_grant_hs ? bus.hs_type : 2'b00;
                  r_timer    <= '0;
                  r_timeout  <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_WAIT_ACTIVE;
               end
            end

            S_WAIT_ACTIVE: begin
               r_timer <= r_timer + 8'd1;
               if (bus.TX_Error) begin
                  r_err   <= 1'b1;
                  r_state <= S_ERR;
               end else if (bus.TX_Transfer_Active) begin
                  r_state <= S_ACTIVE;
               end else if (r_timer == L_TIMER_LAST) begin
                  r_err     <= 1'b1;
                  r_timeout <= 1'b1;
                  r_state   <= S_ERR;
               end
            end

            S_ACTIVE: begin
               if (bus.TX_Error) begin
                  r_err   <= 1'b1;
                  r_state <= S_ERR;
               end else if (!bus.TX_Transfer_Active) begin
                  // DATA is the only type encoded as 00.
                  r_hs_done   <= (r_pkt != 2'b00);
                  r_data_done <= (r_pkt == 2'b00);
                  r_state     <= S_DONE;
               end
            end

            S_DONE, S_ERR: begin
               r_gap <= L_GAP;
               if (GAP_CYCLES == 0) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_GAP;
               end
            end

            S_GAP: begin
               r_gap <= r_gap - 8'd1;
               if (r_gap <= 8'd1) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.TX_packet = r_pkt;
   assign bus.tx_start  = r_start;
   assign bus.hs_gnt    = r_hs_gnt;
   assign bus.data_gnt  = r_data_gnt;
   assign bus.hs_done   = r_hs_done;
   assign bus.data_done = r_data_done;
   assign bus.tx_err    = r_err;
   assign bus.timeout   = r_timeout;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tx_packet_scheduler
// Self-checking bench for tx_packet_scheduler. Expected behaviour comes from
// a packet-level timeline model: the winner of each launch is decided from
// the arbitration rules and a streak count, and the cycle of every pulse is
// computed arithmetically from the TX FSM response chosen for that packet.
// ---------------------------------------------------------------------------
module tb_tx_packet_scheduler;

   localparam int START_TO = 16;
   localparam int GAP      = 4;
   localparam int MAXS     = 3;

   logic clk;
   logic n_rst;
   int   n_total;
   int   n_bad;
   int   m_streak;

   tx_packet_scheduler_if bif ();

   tx_packet_scheduler #(
      .START_TIMEOUT (START_TO),
      .GAP_CYCLES    (GAP),
      .MAX_HS_STREAK (MAXS)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int k,
                      input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (k=%0d): got %0h expected %0h", name, k, act, exp);
      end
   endtask

   task automatic quiesce();
      bif.hs_req             = 1'b0;
      bif.hs_type            = 2'b00;
      bif.data_req           = 1'b0;
      bif.data_len           = '0;
      bif.buff_occ           = '0;
      bif.TX_Transfer_Active = 1'b0;
      bif.TX_Error           = 1'b0;
      tick();
      m_streak = 0;
   endtask

   // Runs one launched packet starting at the cycle where tx_start is visible
   // (k=0) and checks every output until the scheduler is idle again.
   // kind 0: clean (Active high cycles d..d+L-1)
   // kind 1: TX_Error pulse at cycle d+e while Active high from d
   // kind 2: Active never rises (start timeout)
   task automatic run_tail(input logic [1:0] pkt, input bit is_hs,
                           input int kind, input int d, input int L,
                           input int e);
      int E;
      int last;
      if (kind == 0)      E = d + L + 1;
      else if (kind == 1) E = d + e + 1;
      else                E = START_TO;
      last = E + GAP + 1;
      for (int k = 0; k <= last; k++) begin
         bif.TX_Transfer_Active = (kind != 2) && (k >= d) && (k < d + L) && (k < E);
         bif.TX_Error           = (kind == 1) && (k == d + e);
         if (k == 0) begin
            if (is_hs) bif.hs_req = 1'b0;
            else       bif.data_req = 1'b0;
         end
         chk("tx_start",  k, bif.tx_start,  k == 0);
         chk("hs_gnt",    k, bif.hs_gnt,    (k == 0) && is_hs);
         chk("data_gnt",  k, bif.data_gnt,  (k == 0) && !is_hs);
         chk("hs_done",   k, bif.hs_done,   (k == E) && (kind == 0) && is_hs);
         chk("data_done", k, bif.data_done, (k == E) && (kind == 0) && !is_hs);
         chk("tx_err",    k, bif.tx_err,    (k == E) && (kind != 0));
         chk("timeout",   k, bif.timeout,   (kind == 2) && (k >= E));
         chk("busy",      k, bif.busy,      k <= E + GAP);
         if (k <= E + GAP) chk("TX_packet", k, bif.TX_packet, pkt);
         if (k < last) tick();
      end
      bif.TX_Transfer_Active = 1'b0;
      bif.TX_Error           = 1'b0;
   endtask

   // Applies requests in an idle cycle, predicts the winner, and runs the
   // packet. obs/obs_pkt report what the DUT granted (0 none, 1 hs, 2 data).
   task automatic run_packet(input bit hq, input logic [1:0] ht, input bit dq,
                             input int dl, input int bo, input int kind,
                             input int d, input int L, input int e,
                             output int obs, output logic [1:0] obs_pkt);
      bit hv;
      bit de;
      int win;
      hv = hq && (ht != 2'b00);
      de = dq && (dl <= 64) && (bo >= dl);
      if (!dq) m_streak = 0;
      if (hv && !(de && m_streak == MAXS)) win = 1;
      else if (de)                         win = 2;
      else                                 win = 0;
      if (win == 1)      m_streak = dq ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      else if (win == 2) m_streak = 0;

      bif.hs_req   = hq;
      bif.hs_type  = ht;
      bif.data_req = dq;
      bif.data_len = 7'(dl);
      bif.buff_occ = 7'(bo);
      tick();
      obs     = bif.hs_gnt ? 1 : (bif.data_gnt ? 2 : 0);
      obs_pkt = bif.TX_packet;
      if (win == 0) begin
         chk("no_launch", 0, bif.tx_start, 0);
         chk("no_grant",  0, obs, 0);
         chk("idle_busy", 0, bif.busy, 0);
      end else begin
         run_tail((win == 1) ? ht : 2'b00, win == 1, kind, d, L, e);
      end
   endtask

   typedef struct {
      bit         hq;
      logic [1:0] ht;
      bit         dq;
      int         dl;
      int         bo;
      int         exp_win;
      logic [1:0] exp_pkt;
   } arb_vec_t;

   initial begin
      arb_vec_t   tbl[12];
      int         obs;
      logic [1:0] opkt;
      int         order[8];

      tbl[0]  = '{1, 2'b01, 0,  0,   0, 1, 2'b01};
      tbl[1]  = '{1, 2'b10, 0,  0,   0, 1, 2'b10};
      tbl[2]  = '{1, 2'b11, 0,  0,   0, 1, 2'b11};
      tbl[3]  = '{1, 2'b00, 0,  0,   0, 0, 2'b00};
      tbl[4]  = '{0, 2'b00, 1,  8,   8, 2, 2'b00};
      tbl[5]  = '{0, 2'b00, 1,  8,   5, 0, 2'b00};
      tbl[6]  = '{0, 2'b00, 1, 65, 127, 0, 2'b00};
      tbl[7]  = '{0, 2'b00, 1, 64,  64, 2, 2'b00};
      tbl[8]  = '{0, 2'b00, 1,  0,   0, 2, 2'b00};
      tbl[9]  = '{1, 2'b11, 1, 10,  40, 1, 2'b11};
      tbl[10] = '{1, 2'b00, 1, 10,  40, 2, 2'b00};
      tbl[11] = '{1, 2'b10, 1, 65, 127, 1, 2'b10};
      order   = '{1, 1, 1, 2, 1, 1, 1, 2};

      n_total  = 0;
      n_bad    = 0;
      m_streak = 0;

      // Reset state
      n_rst                  = 1'b0;
      bif.hs_req             = 1'b0;
      bif.hs_type            = 2'b00;
      bif.data_req           = 1'b0;
      bif.data_len           = '0;
      bif.buff_occ           = '0;
      bif.TX_Transfer_Active = 1'b0;
      bif.TX_Error           = 1'b0;
      tick();
      tick();
      chk("rst_TX_packet", 0, bif.TX_packet, 0);
      chk("rst_tx_start",  0, bif.tx_start,  0);
      chk("rst_hs_gnt",    0, bif.hs_gnt,    0);
      chk("rst_data_gnt",  0, bif.data_gnt,  0);
      chk("rst_hs_done",   0, bif.hs_done,   0);
      chk("rst_data_done", 0, bif.data_done, 0);
      chk("rst_tx_err",    0, bif.tx_err,    0);
      chk("rst_timeout",   0, bif.timeout,   0);
      chk("rst_busy",      0, bif.busy,      0);
      n_rst = 1'b1;
      tick();

      // Arbitration table, each from a cleared streak
      for (int i = 0; i < 12; i++) begin
         quiesce();
         run_packet(tbl[i].hq, tbl[i].ht, tbl[i].dq, tbl[i].dl, tbl[i].bo,
                    0, 0, 1, 0, obs, opkt);
         chk("tbl_winner", i, obs, tbl[i].exp_win);
         if (tbl[i].exp_win != 0) chk("tbl_pkt", i, opkt, tbl[i].exp_pkt);
      end

      // NAK with 20 cycles of Active
      quiesce();
      run_packet(1, 2'b10, 0, 0, 0, 0, 1, 20, 0, obs, opkt);
      chk("nak_grant", 0, obs, 1);

      // Data gated by buffer occupancy, then released
      quiesce();
      bif.data_req = 1'b1;
      bif.data_len = 7'd8;
      bif.buff_occ = 7'd5;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("gate_no_gnt", i, bif.data_gnt, 0);
         chk("gate_busy",   i, bif.busy,     0);
      end
      bif.buff_occ = 7'd8;
      tick();
      chk("gate_gnt", 0, bif.data_gnt,  1);
      chk("gate_pkt", 0, bif.TX_packet, 2'b00);
      run_tail(2'b00, 1'b0, 0, 1, 3, 0);
      m_streak = 0;

      // Anti-starvation order with handshakes always pending
      quiesce();
      for (int i = 0; i < 8; i++) begin
         run_packet(1, 2'b01, 1, 8, 20, 0, 0, 1, 0, obs, opkt);
         chk("starve_order", i, obs, order[i]);
      end

      // Start timeout, then the next launch clears timeout
      quiesce();
      run_packet(1, 2'b11, 0, 0, 0, 2, 0, 0, 0, obs, opkt);
      run_packet(1, 2'b01, 0, 0, 0, 0, 2, 3, 0, obs, opkt);

      // TX_Error in the same cycle Active falls
      run_packet(1, 2'b01, 0, 0, 0, 1, 2, 5, 5, obs, opkt);

      // Reset in the middle of ACTIVE, request re-granted after release
      quiesce();
      bif.hs_req  = 1'b1;
      bif.hs_type = 2'b01;
      tick();
      chk("rst_mid_launch", 0, bif.tx_start, 1);
      bif.TX_Transfer_Active = 1'b1;
      tick();
      tick();
      tick();
      chk("rst_mid_busy", 0, bif.busy, 1);
      n_rst = 1'b0;
      tick();
      chk("rst_mid_pkt",   0, bif.TX_packet, 0);
      chk("rst_mid_start", 0, bif.tx_start,  0);
      chk("rst_mid_gnt",   0, bif.hs_gnt,    0);
      chk("rst_mid_done",  0, bif.hs_done,   0);
      chk("rst_mid_err",   0, bif.tx_err,    0);
      chk("rst_mid_busy0", 0, bif.busy,      0);
      n_rst                  = 1'b1;
      bif.TX_Transfer_Active = 1'b0;
      m_streak               = 0;
      tick();
      chk("rst_regrant", 0, bif.hs_gnt,    1);
      chk("rst_re_pkt",  0, bif.TX_packet, 2'b01);
      run_tail(2'b01, 1'b1, 0, 0, 2, 0);

      // Randomized rounds against the timeline model
      quiesce();
      for (int r = 0; r < 40; r++) begin
         bit         hq;
         logic [1:0] ht;
         bit         dq;
         int         dl;
         int         bo;
         int         kind;
         int         d;
         int         L;
         int         e;
         int         sel;
         hq = ($urandom % 10) < 7;
         ht = 2'($urandom % 4);
         dq = ($urandom % 10) < 6;
         dl = $urandom_range(0, 68);
         bo = ($urandom % 2 == 0) ? dl + int'($urandom % 10) : int'($urandom % 70);
         if (bo > 127) bo = 127;
         if (!((hq && ht != 2'b00) || (dq && dl <= 64 && bo >= dl))) begin
            hq = 1'b1;
            ht = 2'($urandom_range(1, 3));
         end
         sel  = $urandom % 8;
         kind = (sel < 5) ? 0 : ((sel < 7) ? 1 : 2);
         d    = $urandom % 6;
         L    = 1 + ($urandom % 8);
         e    = $urandom % (L + 1);
         run_packet(hq, ht, dq, dl, bo, kind, d, L, e, obs, opkt);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/tx_packet_scheduler.md
Name: tx_packet_scheduler

Overview:
Sequences the USB TX packet engine: arbitrates between handshake requests (ACK/NAK/STALL from the RX/protocol side) and data-packet requests (from the host/buffer side), and launches one packet at a time. Drives the packet type and a start strobe into the TX FSM, then tracks TX_Transfer_Active and TX_Error until completion. Enforces a start timeout, a minimum inter-packet gap and data anti-starvation.

Parameters:
START_TIMEOUT, 16, max cycles from tx_start until TX_Transfer_Active must rise (range 1..255).
GAP_CYCLES, 4, idle cycles enforced after every packet end or error (0..255; 0 means no gap).
MAX_HS_STREAK, 3, consecutive handshake grants allowed while an eligible data_req waits (1..15).

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  synchronous active-low reset
hs_req  in  1  handshake request, level, held until hs_gnt
hs_type  in  2  01 ACK, 10 NAK, 11 STALL; 00 invalid
data_req  in  1  data-packet request, level, held until data_gnt
data_len  in  7  payload bytes requested, 0..64
buff_occ  in  7  TX buffer occupancy in bytes
TX_Transfer_Active  in  1  TX FSM busy flag
TX_Error  in  1  TX FSM error flag
TX_packet  out  2  packet type to TX FSM: 00 DATA, 01 ACK, 10 NAK, 11 STALL
tx_start  out  1  one-cycle launch strobe
hs_gnt  out  1  one-cycle grant pulse
data_gnt  out  1  one-cycle grant pulse
hs_done  out  1  one-cycle pulse, handshake packet completed cleanly
data_done  out  1  one-cycle pulse, data packet completed cleanly
tx_err  out  1  one-cycle pulse, TX_Error or start timeout
timeout  out  1  sticky; set on start timeout, cleared by next tx_start
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (n_rst low at a clk edge): state IDLE; all outputs 0, including TX_packet=00 and timeout=0; timer, gap counter and streak counter 0. Reset mid-packet aborts immediately; no done/err pulse.
- All outputs registered.
- States: IDLE, WAIT_ACTIVE, ACTIVE, DONE, ERR, GAP.
- Eligibility: hs valid = hs_req && hs_type!=00. data eligible = data_req && data_len<=64 && buff_occ>=data_len. data_len>64 is never granted.
- IDLE arbitration, evaluated in cycle N. Handshake wins unless data is eligible and streak==MAX_HS_STREAK, in which case data wins.
- Winner effects in cycle N+1: tx_start=1, winning gnt=1, TX_packet=type (DATA=00), state WAIT_ACTIVE, timer=0, timeout cleared.
- TX_packet is held stable from N+1 until return to IDLE.
- Streak counter: increments on each hs grant while data_req is high. Cleared on a data grant or whenever data_req is low. Saturates at MAX_HS_STREAK.
- WAIT_ACTIVE: timer increments each cycle.
  - TX_Error=1 -> ERR.
  - Else TX_Transfer_Active=1 -> ACTIVE.
  - Else timer==START_TIMEOUT-1 -> ERR, and set timeout.
- ACTIVE:
  - TX_Error=1 -> ERR. This takes precedence when TX_Error and the Active fall occur in the same cycle.
  - Else TX_Transfer_Active=0 -> DONE.
- DONE: one cycle. Pulse hs_done or data_done according to the latched type. Load gap counter = GAP_CYCLES, go to GAP (or IDLE if GAP_CYCLES=0).
- ERR: one cycle. Pulse tx_err, no done pulse. Load gap counter, go to GAP/IDLE as for DONE.
- GAP: decrement each cycle; at 1 -> IDLE. Requests are not granted in GAP.
- Requests present in IDLE are granted with no bubble; back-to-back packets are separated by exactly GAP_CYCLES+1 non-IDLE cycles after ACTIVE exits.
- A request dropped before grant is simply not granted; no error.

Test Plan:
- Handshake: hs_req=1, hs_type=10 in IDLE at cycle N -> N+1 tx_start=1, hs_gnt=1, TX_packet=10. Active high 20 cycles then low -> hs_done pulse 1 cycle later; after 4 GAP cycles, busy=0.
- Data gating: data_req=1, data_len=8, buff_occ=5 -> no grant. buff_occ rises to 8 -> data_gnt the following cycle, TX_packet=00. Separately, data_len=65 is never granted.
- Starvation: hs_req held continuously with data eligible -> grant order hs, hs, hs, data, hs, ... (MAX_HS_STREAK=3).
- Start timeout: tx_start issued, TX_Transfer_Active held 0 -> after 16 cycles tx_err pulse and timeout=1; next launch clears timeout.
- Error precedence: TX_Error=1 in the same cycle Active falls -> tx_err=1, no done pulse, GAP entered.
- Reset mid-ACTIVE: n_rst=0 for 1 cycle -> next edge all outputs 0, IDLE; held request re-granted after release.
